// File: rtl/exu_pkg.sv
// Shared decode constants, types and immediate extractors for the branch/load-store execution unit.
package exu_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Address-independent part of a queue entry; the address width is set by the top.
    typedef struct packed {
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } lsq_data_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    // funct3[1:0] == 11 has no RV32I meaning and is handled as a word access.
    function automatic size_e dec_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input size_e sz);
        case (sz)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/exu_lsq_fifo.sv
// In-order load/store queue: power-of-two ring buffer with occupancy count and head read-out.
module exu_lsq_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Stale storage is masked so an empty queue always presents zeros.
    assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/exu_bru_lsq.sv
// RV32I branch/JAL resolution plus load/store address generation feeding an in-order request queue.
// Optional misalignment trapping is enabled by defining EXU_MISALIGN_CHK_EN.
module exu_bru_lsq
    import exu_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LSQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iexec_req_vld,
    output logic            iexec_req_rdy,
    input  logic [31:0]     iexec_req_ir,
    input  logic [AW-1:0]   iexec_req_pc,
    input  logic [DW-1:0]   iexec_req_rs1,
    input  logic [DW-1:0]   iexec_req_rs2,
    output logic            iexec_rsp_vld,
    input  logic            iexec_rsp_rdy,
    output logic            iexec_rsp_taken,
    output logic [AW-1:0]   iexec_rsp_offset,
    output logic            iexec_rsp_ldst,
    output logic            iexec_rsp_exc,
    output logic            ldst_req_vld,
    input  logic            ldst_req_rdy,
    output logic            ldst_req_wr,
    output logic [AW-1:0]   ldst_req_addr,
    output logic [DW-1:0]   ldst_req_wdata,
    output logic [DW/8-1:0] ldst_req_strb
);

    typedef struct packed {
        logic [AW-1:0] addr;
        lsq_data_t     data;
    } lsq_entry_t;

    logic          rsp_vld_q, rsp_vld_d;
    logic          rsp_taken_q, rsp_taken_d;
    logic [AW-1:0] rsp_offset_q, rsp_offset_d;
    logic          rsp_ldst_q, rsp_ldst_d;
    logic          rsp_exc_q, rsp_exc_d;

    logic          accept;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          br_taken;
    size_e         size;
    logic [31:0]   ls_imm;
    logic [AW-1:0] ls_addr;
    logic          misalign;
    logic [3:0]    ls_strb;
    logic [31:0]   ls_wdata;
    logic          is_ldst;
    logic          dec_taken, dec_ldst, dec_exc;
    logic [AW-1:0] dec_offset;

    lsq_entry_t    push_entry, head_entry;
    logic          lsq_push, lsq_empty, lsq_full;
    logic [$clog2(LSQ_DEPTH):0] unused_lsq_count;
    logic          unused_pc;

    assign unused_pc = ^iexec_req_pc;

    assign iexec_req_rdy = ~rst & (~rsp_vld_q | iexec_rsp_rdy) & ~lsq_full;
    assign accept        = iexec_req_vld & iexec_req_rdy;

    always_comb begin
        opcode = iexec_req_ir[6:0];
        funct3 = iexec_req_ir[14:12];

        case (funct3)
            F3_BEQ:  br_taken = (iexec_req_rs1 == iexec_req_rs2);
            F3_BNE:  br_taken = (iexec_req_rs1 != iexec_req_rs2);
            F3_BLT:  br_taken = ($signed(iexec_req_rs1) <  $signed(iexec_req_rs2));
            F3_BGE:  br_taken = ($signed(iexec_req_rs1) >= $signed(iexec_req_rs2));
            F3_BLTU: br_taken = (iexec_req_rs1 <  iexec_req_rs2);
            F3_BGEU: br_taken = (iexec_req_rs1 >= iexec_req_rs2);
            default: br_taken = 1'b0;
        endcase

        size    = dec_size(funct3[1:0]);
        ls_imm  = (opcode == OPC_STORE) ? imm_s(iexec_req_ir) : imm_i(iexec_req_ir);
        ls_addr = AW'(iexec_req_rs1) + AW'($signed(ls_imm));
        ls_strb = size_mask(size) << ls_addr[1:0];

        case (size)
            SZ_BYTE: ls_wdata = {4{iexec_req_rs2[7:0]}};
            SZ_HALF: ls_wdata = {2{iexec_req_rs2[15:0]}};
            default: ls_wdata = iexec_req_rs2;
        endcase

`ifdef EXU_MISALIGN_CHK_EN
        misalign = ((size == SZ_HALF) && ls_addr[0]) ||
                   ((size == SZ_WORD) && (ls_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif

        is_ldst    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
        dec_taken  = 1'b0;
        dec_offset = '0;
        dec_ldst   = 1'b0;
        dec_exc    = 1'b0;
        case (opcode)
            OPC_BRANCH: begin
                dec_taken  = br_taken;
                dec_offset = AW'($signed(imm_b(iexec_req_ir)));
            end
            OPC_JAL: begin
                dec_taken  = 1'b1;
                dec_offset = AW'($signed(imm_j(iexec_req_ir)));
            end
            OPC_LOAD, OPC_STORE: begin
                dec_ldst = ~misalign;
                dec_exc  = misalign;
            end
            default: ;
        endcase
    end

    always_comb begin
        push_entry.addr       = ls_addr;
        push_entry.data.wr    = (opcode == OPC_STORE);
        push_entry.data.wdata = ls_wdata;
        push_entry.data.strb  = ls_strb;
        lsq_push              = accept & is_ldst & ~misalign;
    end

    // The response register only advances on accept or drain; fields hold while stalled.
    always_comb begin
        rsp_vld_d    = rsp_vld_q;
        rsp_taken_d  = rsp_taken_q;
        rsp_offset_d = rsp_offset_q;
        rsp_ldst_d   = rsp_ldst_q;
        rsp_exc_d    = rsp_exc_q;
        if (accept) begin
            rsp_vld_d    = 1'b1;
            rsp_taken_d  = dec_taken;
            rsp_offset_d = dec_offset;
            rsp_ldst_d   = dec_ldst;
            rsp_exc_d    = dec_exc;
        end else if (iexec_rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q    <= 1'b0;
            rsp_taken_q  <= 1'b0;
            rsp_offset_q <= '0;
            rsp_ldst_q   <= 1'b0;
            rsp_exc_q    <= 1'b0;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_taken_q  <= rsp_taken_d;
            rsp_offset_q <= rsp_offset_d;
            rsp_ldst_q   <= rsp_ldst_d;
            rsp_exc_q    <= rsp_exc_d;
        end
    end

    assign iexec_rsp_vld    = rsp_vld_q;
    assign iexec_rsp_taken  = rsp_taken_q;
    assign iexec_rsp_offset = rsp_offset_q;
    assign iexec_rsp_ldst   = rsp_ldst_q;
    assign iexec_rsp_exc    = rsp_exc_q;

    exu_lsq_fifo #(
        .DEPTH   (LSQ_DEPTH),
        .entry_t (lsq_entry_t)
    ) u_lsq (
        .clk       (clk),
        .rst       (rst),
        .push      (lsq_push),
        .push_data (push_entry),
        .pop       (ldst_req_rdy),
        .head      (head_entry),
        .empty     (lsq_empty),
        .full      (lsq_full),
        .count     (unused_lsq_count)
    );

    assign ldst_req_vld   = ~lsq_empty;
    assign ldst_req_wr    = head_entry.data.wr;
    assign ldst_req_addr  = head_entry.addr;
    assign ldst_req_wdata = head_entry.data.wdata;
    assign ldst_req_strb  = head_entry.data.strb;

endmodule

// File: tb/tb_exu_bru_lsq.sv
// Directed scoreboard bench for exu_bru_lsq: expectations queued at issue, checked on each handshake.
module tb_exu_bru_lsq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iexec_req_vld = 1'b0;
    logic        iexec_req_rdy;
    logic [31:0] iexec_req_ir = '0;
    logic [31:0] iexec_req_pc = '0;
    logic [31:0] iexec_req_rs1 = '0;
    logic [31:0] iexec_req_rs2 = '0;
    logic        iexec_rsp_vld;
    logic        iexec_rsp_rdy = 1'b1;
    logic        iexec_rsp_taken;
    logic [31:0] iexec_rsp_offset;
    logic        iexec_rsp_ldst;
    logic        iexec_rsp_exc;
    logic        ldst_req_vld;
    logic        ldst_req_rdy = 1'b1;
    logic        ldst_req_wr;
    logic [31:0] ldst_req_addr;
    logic [31:0] ldst_req_wdata;
    logic [3:0]  ldst_req_strb;

    int errors = 0;
    int checks = 0;
    int n_rsp = 0;
    int n_req = 0;

    typedef struct packed {
        logic        taken;
        logic [31:0] off;
        logic        ldst;
        logic        exc;
    } rsp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];

    exu_bru_lsq #(.AW(32), .DW(32), .LSQ_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .iexec_req_vld    (iexec_req_vld),
        .iexec_req_rdy    (iexec_req_rdy),
        .iexec_req_ir     (iexec_req_ir),
        .iexec_req_pc     (iexec_req_pc),
        .iexec_req_rs1    (iexec_req_rs1),
        .iexec_req_rs2    (iexec_req_rs2),
        .iexec_rsp_vld    (iexec_rsp_vld),
        .iexec_rsp_rdy    (iexec_rsp_rdy),
        .iexec_rsp_taken  (iexec_rsp_taken),
        .iexec_rsp_offset (iexec_rsp_offset),
        .iexec_rsp_ldst   (iexec_rsp_ldst),
        .iexec_rsp_exc    (iexec_rsp_exc),
        .ldst_req_vld     (ldst_req_vld),
        .ldst_req_rdy     (ldst_req_rdy),
        .ldst_req_wr      (ldst_req_wr),
        .ldst_req_addr    (ldst_req_addr),
        .ldst_req_wdata   (ldst_req_wdata),
        .ldst_req_strb    (ldst_req_strb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_l(input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd1, f3, 5'd3, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic rsp_t mk_rsp(input logic t, input logic [31:0] off, input logic l, input logic e);
        rsp_t r;
        r.taken = t; r.off = off; r.ldst = l; r.exc = e;
        return r;
    endfunction

    function automatic req_t mk_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d; r.strb = s;
        return r;
    endfunction

    // Drive one instruction, wait (bounded) for ready, queue its expectations, hold for the accept edge.
    task automatic issue(input logic [31:0] ir, input logic [31:0] rs1, input logic [31:0] rs2,
                         input rsp_t er, input logic has_req, input req_t eq);
        int n = 0;
        iexec_req_vld = 1'b1;
        iexec_req_ir  = ir;
        iexec_req_rs1 = rs1;
        iexec_req_rs2 = rs2;
        iexec_req_pc  = iexec_req_pc + 32'd4;
        while (iexec_req_rdy !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_rdy", 128'(iexec_req_rdy), 128'(1'b1));
        rsp_q.push_back(er);
        if (has_req) req_q.push_back(eq);
        @(posedge clk); #1;
        iexec_req_vld = 1'b0;
    endtask

    // Outputs sampled mid-cycle; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && iexec_rsp_vld && iexec_rsp_rdy) begin
            n_rsp++;
            $display("rsp %0d: taken=%0d offset=%h ldst=%0d exc=%0d",
                     n_rsp, iexec_rsp_taken, iexec_rsp_offset, iexec_rsp_ldst, iexec_rsp_exc);
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 128'(1'b1), 128'(1'b0));
            end else begin
                check($sformatf("rsp%0d", n_rsp),
                      128'({iexec_rsp_taken, iexec_rsp_offset, iexec_rsp_ldst, iexec_rsp_exc}),
                      128'(rsp_q.pop_front()));
            end
        end
        if (!rst && ldst_req_vld && ldst_req_rdy) begin
            n_req++;
            $display("ldst %0d: wr=%0d addr=%h wdata=%h strb=%b",
                     n_req, ldst_req_wr, ldst_req_addr, ldst_req_wdata, ldst_req_strb);
            if (req_q.size() == 0) begin
                check("ldst_unexpected", 128'(1'b1), 128'(1'b0));
            end else begin
                check($sformatf("ldst%0d", n_req),
                      128'({ldst_req_wr, ldst_req_addr, ldst_req_wdata, ldst_req_strb}),
                      128'(req_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t none;
        rsp_t lsr;
        int   n;
        none = '0;
        lsr  = mk_rsp(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset behaviour
        #2;
        check("rdy_in_reset", 128'(iexec_req_rdy), 128'(1'b0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_reset", 128'(iexec_req_rdy), 128'(1'b1));
        check("rsp_reset", 128'({iexec_rsp_vld, iexec_rsp_taken, iexec_rsp_offset, iexec_rsp_ldst, iexec_rsp_exc}), 128'(0));
        check("ldst_reset", 128'({ldst_req_vld, ldst_req_wr, ldst_req_addr, ldst_req_wdata, ldst_req_strb}), 128'(0));

        // Branches, jumps, nop
        issue(enc_b(3'b000, 13'h1FF8), 32'd5, 32'd5, mk_rsp(1'b1, 32'hFFFFFFF8, 1'b0, 1'b0), 1'b0, none);
        issue(enc_b(3'b110, 13'd12), 32'd1, 32'hFFFFFFFF, mk_rsp(1'b1, 32'h0000000C, 1'b0, 1'b0), 1'b0, none);
        issue(enc_b(3'b100, 13'd12), 32'd1, 32'hFFFFFFFF, mk_rsp(1'b0, 32'h0000000C, 1'b0, 1'b0), 1'b0, none);
        issue(enc_b(3'b001, 13'h1000), 32'd5, 32'd5, mk_rsp(1'b0, 32'hFFFFF000, 1'b0, 1'b0), 1'b0, none);
        issue(enc_b(3'b101, 13'h0FFE), 32'hFFFFFFFD, 32'd2, mk_rsp(1'b0, 32'h00000FFE, 1'b0, 1'b0), 1'b0, none);
        issue(enc_b(3'b111, 13'd4), 32'hFFFFFFFD, 32'd2, mk_rsp(1'b1, 32'h00000004, 1'b0, 1'b0), 1'b0, none);
        issue(enc_b(3'b010, 13'd8), 32'd7, 32'd7, mk_rsp(1'b0, 32'h00000008, 1'b0, 1'b0), 1'b0, none);
        issue(enc_j(21'h1FFFFE), 32'd0, 32'd0, mk_rsp(1'b1, 32'hFFFFFFFE, 1'b0, 1'b0), 1'b0, none);
        issue(32'h00A08093, 32'd9, 32'd9, mk_rsp(1'b0, 32'h0, 1'b0, 1'b0), 1'b0, none);

        // Loads and stores with the memory side always ready
        issue(enc_s(3'b000, 12'd3), 32'h1000, 32'hAB, lsr, 1'b1,
              mk_req(1'b1, 32'h1003, 32'hABABABAB, 4'b1000));
        issue(enc_s(3'b001, 12'hFFE), 32'h2000, 32'h1234CDEF, lsr, 1'b1,
              mk_req(1'b1, 32'h1FFE, 32'hCDEFCDEF, 4'b1100));
        issue(enc_l(3'b000, 12'd1), 32'h10, 32'h0, lsr, 1'b1,
              mk_req(1'b0, 32'h11, 32'h0, 4'b0010));
        issue(enc_l(3'b010, 12'd8), 32'hFFFFFFFC, 32'h0, lsr, 1'b1,
              mk_req(1'b0, 32'h4, 32'h0, 4'b1111));
`ifdef EXU_MISALIGN_CHK_EN
        issue(enc_l(3'b010, 12'd0), 32'h1002, 32'h0, mk_rsp(1'b0, 32'h0, 1'b0, 1'b1), 1'b0, none);
`else
        issue(enc_l(3'b010, 12'd0), 32'h1002, 32'h0, lsr, 1'b1,
              mk_req(1'b0, 32'h1002, 32'h0, 4'b1100));
`endif
        repeat (3) @(posedge clk);
        #1;
        check("drain_simple", 128'(req_q.size()), 128'(0));

        // Fill the queue while memory stalls, then release a single pop
        ldst_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(enc_s(3'b010, 12'(4 * i)), 32'h100, 32'h11111111 * (i + 1), lsr, 1'b1,
                  mk_req(1'b1, 32'h100 + 32'(4 * i), 32'h11111111 * (i + 1), 4'b1111));
        end
        check("full_rdy_low", 128'(iexec_req_rdy), 128'(1'b0));
        check("full_ldst_vld", 128'(ldst_req_vld), 128'(1'b1));
        ldst_req_rdy = 1'b1;
        @(posedge clk); #1;
        ldst_req_rdy = 1'b0;
        check("one_pop_rdy", 128'(iexec_req_rdy), 128'(1'b1));
        check("one_pop_left", 128'(req_q.size()), 128'(3));
        ldst_req_rdy = 1'b1;
        n = 0;
        while (req_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_full", 128'(req_q.size()), 128'(0));

        // Response back-pressure holds the JAL result and blocks issue
        iexec_rsp_rdy = 1'b0;
        issue(enc_j(21'd16), 32'd0, 32'd0, mk_rsp(1'b1, 32'h10, 1'b0, 1'b0), 1'b0, none);
        check("hold_rdy_low", 128'(iexec_req_rdy), 128'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("hold_fields", 128'({iexec_rsp_vld, iexec_rsp_taken, iexec_rsp_offset}), 128'({1'b1, 1'b1, 32'h10}));
        check("hold_rdy_still_low", 128'(iexec_req_rdy), 128'(1'b0));
        iexec_rsp_rdy = 1'b1;
        @(posedge clk); #1;
        check("hold_released", 128'(rsp_q.size()), 128'(0));
        check("rdy_after_release", 128'(iexec_req_rdy), 128'(1'b1));

        // Asynchronous reset discards a pending response and a queued store
        iexec_rsp_rdy = 1'b0;
        ldst_req_rdy  = 1'b0;
        issue(enc_s(3'b010, 12'd0), 32'h40, 32'h5A5A5A5A, lsr, 1'b1,
              mk_req(1'b1, 32'h40, 32'h5A5A5A5A, 4'b1111));
        check("pre_reset_busy", 128'({iexec_rsp_vld, ldst_req_vld}), 128'(2'b11));
        #2 rst = 1'b1;
        #1;
        check("async_reset_clear", 128'({iexec_rsp_vld, ldst_req_vld, iexec_req_rdy, ldst_req_addr}), 128'(0));
        rsp_q.delete();
        req_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        iexec_rsp_rdy = 1'b1;
        ldst_req_rdy  = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 128'({iexec_req_rdy, iexec_rsp_vld, ldst_req_vld}), 128'(3'b100));

        repeat (4) @(posedge clk);
        #1;
        check("rsp_queue_empty", 128'(rsp_q.size()), 128'(0));
        check("req_queue_empty", 128'(req_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
